// File: rtl/piano_notes_pkg.sv
// Note codes and C4..B4 period tables shared by the tone generators and the detector.
// Latency: none, constants and pure functions only.
// Backpressure: not applicable.
package piano_notes_pkg;

   // Period counter and period bus width
   localparam int CNT_W     = 20;
   localparam int NUM_NOTES = 7;

   typedef enum logic [2:0] {
      NOTE_NONE = 3'd0,
      NOTE_DO   = 3'd1,
      NOTE_RE   = 3'd2,
      NOTE_MI   = 3'd3,
      NOTE_FA   = 3'd4,
      NOTE_SOL  = 3'd5,
      NOTE_LA   = 3'd6,
      NOTE_SI   = 3'd7
   } note_t;

   // Half periods in 50 MHz cycles; the generators toggle their output at these counts
   localparam int HALF_DO  = 95556;
   localparam int HALF_RE  = 85132;
   localparam int HALF_MI  = 75843;
   localparam int HALF_FA  = 71586;
   localparam int HALF_SOL = 63776;
   localparam int HALF_LA  = 56818;
   localparam int HALF_SI  = 50620;

   // Full periods, which is what the detector measures between rising edges
   localparam int FULL_DO  = 2 * HALF_DO;
   localparam int FULL_RE  = 2 * HALF_RE;
   localparam int FULL_MI  = 2 * HALF_MI;
   localparam int FULL_FA  = 2 * HALF_FA;
   localparam int FULL_SOL = 2 * HALF_SOL;
   localparam int FULL_LA  = 2 * HALF_LA;
   localparam int FULL_SI  = 2 * HALF_SI;

   typedef enum logic [1:0] {
      ST_SILENT,
      ST_ARMED,
      ST_TRACK,
      ST_LOCKED
   } det_state_t;

   // Full-period table indexed by note code; code 0 (no note) has no period
   function automatic int full_period(input int code);
      case (code)
         1:       full_period = FULL_DO;
         2:       full_period = FULL_RE;
         3:       full_period = FULL_MI;
         4:       full_period = FULL_FA;
         5:       full_period = FULL_SOL;
         6:       full_period = FULL_LA;
         7:       full_period = FULL_SI;
         default: full_period = 0;
      endcase
   endfunction

endpackage

// File: rtl/tone_note_detector_if.sv
// Tone input and note report bundle between the pin/loopback side and the detector.
// Latency: none, wiring only.
// Backpressure: none; the tone is free-running and the reports are level/pulse outputs.
interface tone_note_detector_if #(
   parameter int CNT_W = piano_notes_pkg::CNT_W
);
   logic             tone_in;
   logic [CNT_W-1:0] period;
   logic             period_strobe;
   logic [2:0]       note_id;
   logic             note_valid;

   modport master (
      output tone_in,
      input  period,
      input  period_strobe,
      input  note_id,
      input  note_valid
   );

   modport slave (
      input  tone_in,
      output period,
      output period_strobe,
      output note_id,
      output note_valid
   );
endinterface

// File: rtl/tone_period_meter.sv
// Synchronises the tone pin, detects rising edges and measures edge-to-edge period; flags silence.
// Latency: edge pulse 3 cycles after the pin edge, period/strobe 1 cycle after the edge pulse.
// Backpressure: none; every capture is presented once as a one-cycle strobe.
module tone_period_meter #(
   parameter int CNT_W   = piano_notes_pkg::CNT_W,
   parameter int TIMEOUT = 262143
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tone_in,
   output logic [CNT_W-1:0] period,
   output logic             period_strobe,
   output logic             edge_pulse,
   output logic             timeout
);
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;
   localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

   logic             sync1;
   logic             sync2;
   logic             sync_prev;
   logic [CNT_W-1:0] cnt;
   logic             primed;   // a previous edge exists, so the next edge closes a period

   // Two-flop synchroniser plus one history flop; edge pulse is registered
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1      <= 1'b0;
         sync2      <= 1'b0;
         sync_prev  <= 1'b0;
         edge_pulse <= 1'b0;
      end else begin
         sync1      <= tone_in;
         sync2      <= sync1;
         sync_prev  <= sync2;
         edge_pulse <= sync2 & ~sync_prev;
      end
   end

   // Silence is only meaningful once armed; a coincident edge takes priority
   assign timeout = primed && (cnt == TIMEOUT_CNT) && !edge_pulse;

   // Saturating gap counter; captures on each edge once primed, restarts at 1 so a
   // gap of N cycles between edge pulses reads back as exactly N
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt           <= '0;
         primed        <= 1'b0;
         period        <= '0;
         period_strobe <= 1'b0;
      end else begin
         period_strobe <= 1'b0;
         if (edge_pulse) begin
            cnt    <= CNT_W'(1);
            primed <= 1'b1;
            if (primed) begin
               period        <= cnt;
               period_strobe <= 1'b1;
            end
         end else begin
            if (cnt != CNT_MAX) begin
               cnt <= cnt + 1'b1;
            end
            if (timeout) begin
               primed <= 1'b0;
            end
         end
      end
   end
endmodule

// File: rtl/tone_note_detector.sv
// Classifies a measured tone period as Do..Si and reports it once stable for STABLE_COUNT periods.
// Latency: note_id/note_valid update 1 cycle after the deciding period_strobe; 3 cycles pin-to-edge.
// Backpressure: none; outputs are levels plus a one-cycle period strobe.
module tone_note_detector #(
   parameter int CNT_W        = piano_notes_pkg::CNT_W,
   parameter int TOL_SHIFT    = 6,
   parameter int STABLE_COUNT = 3,
   parameter int TIMEOUT      = 262143,
   parameter int TABLE_SHIFT  = 0    // scales the period table down for a faster clock-to-tone ratio
) (
   input logic                 clk,
   input logic                 rst,
   tone_note_detector_if.slave bus
);
   import piano_notes_pkg::*;

   localparam int MC_W = $clog2(STABLE_COUNT + 1);

   logic [CNT_W-1:0] period;
   logic             period_strobe;
   logic             edge_pulse;
   logic             timeout;
   int               meas;
   note_t            cand;
   det_state_t       state;
   note_t            track_id;
   logic [MC_W-1:0]  match_cnt;
   logic [MC_W-1:0]  match_next;
   note_t            lock_id;
   logic             lock_valid;

   tone_period_meter #(
      .CNT_W   (CNT_W),
      .TIMEOUT (TIMEOUT)
   ) meter (
      .clk           (clk),
      .rst           (rst),
      .tone_in       (bus.tone_in),
      .period        (period),
      .period_strobe (period_strobe),
      .edge_pulse    (edge_pulse),
      .timeout       (timeout)
   );

   assign bus.period        = period;
   assign bus.period_strobe = period_strobe;
   assign bus.note_id       = lock_id;
   assign bus.note_valid    = lock_valid;

   // True when the measurement is within +/- (ref >> TOL_SHIFT) of the reference period
   function automatic logic in_window(input int m, input int ref_p);
      int diff;
      diff = (m > ref_p) ? (m - ref_p) : (ref_p - m);
      return (diff <= (ref_p >> TOL_SHIFT));
   endfunction

   // Table lookup on the freshly captured period; windows are disjoint so at most one hits
   always_comb begin
      meas = 32'(period);
      cand = NOTE_NONE;
      for (int i = 1; i <= NUM_NOTES; i++) begin
         if (in_window(meas, full_period(i) >> TABLE_SHIFT)) begin
            cand = note_t'(3'(i));
         end
      end
   end

   assign match_next = match_cnt + 1'b1;

   // Note tracking FSM: strobe decisions first, then silence, then arming on the first edge
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_SILENT;
         track_id   <= NOTE_NONE;
         match_cnt  <= '0;
         lock_id    <= NOTE_NONE;
         lock_valid <= 1'b0;
      end else if (period_strobe && state != ST_SILENT) begin
         if (cand == NOTE_NONE) begin
            state      <= ST_ARMED;
            track_id   <= NOTE_NONE;
            match_cnt  <= '0;
            lock_id    <= NOTE_NONE;
            lock_valid <= 1'b0;
         end else if (state != ST_ARMED && cand == track_id) begin
            // Same note again: count towards lock while tracking, hold while locked
            if (state == ST_TRACK) begin
               match_cnt <= match_next;
               if (match_next >= MC_W'(STABLE_COUNT)) begin
                  state      <= ST_LOCKED;
                  lock_id    <= track_id;
                  lock_valid <= 1'b1;
               end
            end
         end else begin
            // First match, or a different note: start counting afresh on this one
            track_id  <= cand;
            match_cnt <= MC_W'(1);
            if (STABLE_COUNT <= 1) begin
               state      <= ST_LOCKED;
               lock_id    <= cand;
               lock_valid <= 1'b1;
            end else begin
               state      <= ST_TRACK;
               lock_id    <= NOTE_NONE;
               lock_valid <= 1'b0;
            end
         end
      end else if (timeout) begin
         state      <= ST_SILENT;
         track_id   <= NOTE_NONE;
         match_cnt  <= '0;
         lock_id    <= NOTE_NONE;
         lock_valid <= 1'b0;
      end else if (state == ST_SILENT && edge_pulse) begin
         state <= ST_ARMED;
      end
   end
endmodule
